// File: rtl/pit_pkg.sv
// Shared register-map constants for the PIT register blocks (single- and multi-channel).
package pit_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_MOD    = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } reg_ofs_e;

  localparam int GCTRL_STOP_LSB = 8;

  localparam int CTRL_SLAVE_BIT = 15;
  localparam int CTRL_PRE_LSB   = 8;
  localparam int CTRL_PRE_W     = 4;
  localparam int CTRL_IEN_BIT   = 1;
  localparam int CTRL_EN_BIT    = 0;

  localparam int STAT_FLG_BIT = 0;
  localparam int STAT_OVF_BIT = 1;

  // Byte-lane merge of a write into an existing 16-bit register image.
  function automatic logic [15:0] merge_be(input logic [15:0] old_v,
                                           input logic [15:0] new_v,
                                           input logic [1:0]  be);
    return {be[1] ? new_v[15:8] : old_v[15:8],
            be[0] ? new_v[7:0]  : old_v[7:0]};
  endfunction

endpackage

// File: rtl/pit_ch_regs.sv
// One PIT channel: CTRL, MOD, sticky STATUS (W1C) and registered interrupt.
module pit_ch_regs
  import pit_pkg::*;
#(
  parameter int   COUNT_SIZE  = 16,
  parameter logic NO_PRESCALE = 1'b0
) (
  input  logic                  bus_clk,
  input  logic                  async_rst_b,
  input  logic                  sync_reset,
  input  logic                  ctrl_we,
  input  logic                  mod_we,
  input  logic                  stat_we,
  input  logic [1:0]            wr_be,
  input  logic [15:0]           wdata,
  input  logic                  g_start,
  input  logic                  g_stop,
  input  logic                  cnt_flag,
  output logic [COUNT_SIZE-1:0] mod_value,
  output logic [3:0]            pre_scl,
  output logic                  slave,
  output logic                  cnt_en,
  output logic                  irq,
  output logic                  flg,
  output logic [15:0]           ctrl_rd,
  output logic [15:0]           mod_rd,
  output logic [15:0]           stat_rd
);

  logic                  slave_q, slave_d;
  logic [3:0]            pre_q, pre_d;
  logic                  ien_q, ien_d;
  logic                  en_q, en_d;
  logic [COUNT_SIZE-1:0] mod_q, mod_d;
  logic                  flg_q, flg_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_q, irq_d;

  logic [15:0] ctrl_new;
  logic        unused_ctrl;
  logic        clr_flg, clr_ovf;

  always_comb begin
    ctrl_rd                                 = '0;
    ctrl_rd[CTRL_SLAVE_BIT]                 = slave_q;
    ctrl_rd[CTRL_PRE_LSB +: CTRL_PRE_W]     = pre_q;
    ctrl_rd[CTRL_IEN_BIT]                   = ien_q;
    ctrl_rd[CTRL_EN_BIT]                    = en_q;
    stat_rd                                 = '0;
    stat_rd[STAT_FLG_BIT]                   = flg_q;
    stat_rd[STAT_OVF_BIT]                   = ovf_q;
  end

  assign mod_rd      = 16'(mod_q);
  assign ctrl_new    = merge_be(ctrl_rd, wdata, wr_be);
  assign unused_ctrl = ^ctrl_new;
  assign clr_flg     = stat_we & wr_be[0] & wdata[STAT_FLG_BIT];
  assign clr_ovf     = stat_we & wr_be[0] & wdata[STAT_OVF_BIT];

  // A counter rollover always wins over a simultaneous W1C of flg.
  always_comb begin
    slave_d = slave_q;
    pre_d   = pre_q;
    ien_d   = ien_q;
    en_d    = en_q;
    mod_d   = mod_q;
    flg_d   = flg_q;
    ovf_d   = ovf_q;
    irq_d   = flg_q & ien_q;

    if (ctrl_we) begin
      slave_d = ctrl_new[CTRL_SLAVE_BIT];
      pre_d   = NO_PRESCALE ? '0 : ctrl_new[CTRL_PRE_LSB +: CTRL_PRE_W];
      ien_d   = ctrl_new[CTRL_IEN_BIT];
      en_d    = ctrl_new[CTRL_EN_BIT];
    end
    if (g_start) en_d = 1'b1;
    if (g_stop)  en_d = 1'b0;

    if (mod_we) mod_d = COUNT_SIZE'(merge_be(16'(mod_q), wdata, wr_be));

    if (cnt_flag)     flg_d = 1'b1;
    else if (clr_flg) flg_d = 1'b0;

    if (cnt_flag && flg_q && !clr_flg) ovf_d = 1'b1;
    else if (clr_ovf)                  ovf_d = 1'b0;

    if (sync_reset) begin
      slave_d = 1'b0;
      pre_d   = '0;
      ien_d   = 1'b0;
      en_d    = 1'b0;
      mod_d   = '0;
      flg_d   = 1'b0;
      ovf_d   = 1'b0;
      irq_d   = 1'b0;
    end
  end

  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      slave_q <= 1'b0;
      pre_q   <= '0;
      ien_q   <= 1'b0;
      en_q    <= 1'b0;
      mod_q   <= '0;
      flg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      slave_q <= slave_d;
      pre_q   <= pre_d;
      ien_q   <= ien_d;
      en_q    <= en_d;
      mod_q   <= mod_d;
      flg_q   <= flg_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  assign mod_value = mod_q;
  assign pre_scl   = pre_q;
  assign slave     = slave_q;
  assign cnt_en    = en_q;
  assign irq       = irq_q;
  assign flg       = flg_q;

endmodule

// File: rtl/pit_mch_regs.sv
// Multi-channel PIT register file: address decode, GCTRL start/stop fan-out,
// registered read mux and combined interrupt over NUM_CH pit_ch_regs instances.
module pit_mch_regs
  import pit_pkg::*;
#(
  parameter int   NUM_CH      = 4,
  parameter int   COUNT_SIZE  = 16,
  parameter int   DWIDTH      = 16,
  parameter logic NO_PRESCALE = 1'b0,
  parameter int   ADDR_W      = 5
) (
  input  logic                         bus_clk,
  input  logic                         async_rst_b,
  input  logic                         sync_reset,
  input  logic                         wr_en,
  input  logic [1:0]                   wr_be,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         rd_en,
  input  logic [DWIDTH-1:0]            write_bus,
  output logic [15:0]                  read_data,
  output logic                         rd_valid,
  input  logic [NUM_CH-1:0]            cnt_flag_i,
  output logic [NUM_CH*COUNT_SIZE-1:0] mod_value,
  output logic [NUM_CH*4-1:0]          pit_pre_scl,
  output logic [NUM_CH-1:0]            pit_slave,
  output logic [NUM_CH-1:0]            cnt_en_o,
  output logic [NUM_CH-1:0]            pit_irq_o,
  output logic                         irq_any_o
);

  localparam int                CH_IDX_W   = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] GCTRL_ADDR = ADDR_W'(4 * NUM_CH);

  logic [15:0]         wdata;
  logic [CH_IDX_W-1:0] ch_idx;
  reg_ofs_e            ofs;
  logic                in_range, gctrl_hit;
  logic [NUM_CH-1:0]   g_start, g_stop, ch_flg, ch_irq;
  logic [15:0]         ctrl_rd [NUM_CH];
  logic [15:0]         mod_rd  [NUM_CH];
  logic [15:0]         stat_rd [NUM_CH];
  logic [15:0]         rd_mux;

  logic [15:0] read_data_q, read_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        irq_any_q, irq_any_d;

  // An 8-bit bus presents the same byte on both lanes; wr_be picks the lane.
  generate
    if (DWIDTH == 8) begin : g_bus8
      assign wdata = {2{write_bus}};
    end else begin : g_bus16
      assign wdata = 16'(write_bus);
    end
  endgenerate

  assign ch_idx    = addr[ADDR_W-1:2];
  assign ofs       = reg_ofs_e'(addr[1:0]);
  assign in_range  = addr < GCTRL_ADDR;
  assign gctrl_hit = addr == GCTRL_ADDR;
  assign g_start   = (wr_en && gctrl_hit && wr_be[0]) ? wdata[NUM_CH-1:0] : '0;
  assign g_stop    = (wr_en && gctrl_hit && wr_be[1]) ? wdata[GCTRL_STOP_LSB +: NUM_CH] : '0;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic ch_hit;
      assign ch_hit = wr_en && in_range && (ch_idx == CH_IDX_W'(c));

      pit_ch_regs #(
        .COUNT_SIZE (COUNT_SIZE),
        .NO_PRESCALE(NO_PRESCALE)
      ) u_ch (
        .bus_clk    (bus_clk),
        .async_rst_b(async_rst_b),
        .sync_reset (sync_reset),
        .ctrl_we    (ch_hit && (ofs == REG_CTRL)),
        .mod_we     (ch_hit && (ofs == REG_MOD)),
        .stat_we    (ch_hit && (ofs == REG_STATUS)),
        .wr_be      (wr_be),
        .wdata      (wdata),
        .g_start    (g_start[c]),
        .g_stop     (g_stop[c]),
        .cnt_flag   (cnt_flag_i[c]),
        .mod_value  (mod_value[c*COUNT_SIZE +: COUNT_SIZE]),
        .pre_scl    (pit_pre_scl[c*4 +: 4]),
        .slave      (pit_slave[c]),
        .cnt_en     (cnt_en_o[c]),
        .irq        (ch_irq[c]),
        .flg        (ch_flg[c]),
        .ctrl_rd    (ctrl_rd[c]),
        .mod_rd     (mod_rd[c]),
        .stat_rd    (stat_rd[c])
      );
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    if (in_range) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == CH_IDX_W'(i)) begin
          case (ofs)
            REG_CTRL:   rd_mux = ctrl_rd[i];
            REG_MOD:    rd_mux = mod_rd[i];
            REG_STATUS: rd_mux = stat_rd[i];
            default:    rd_mux = '0;
          endcase
        end
      end
    end else if (gctrl_hit) begin
      rd_mux[NUM_CH-1:0]               = ch_flg;
      rd_mux[GCTRL_STOP_LSB +: NUM_CH] = ch_irq;
    end
  end

  // Read data samples pre-edge register state, so a same-cycle write is not visible.
  always_comb begin
    read_data_d = rd_en ? rd_mux : read_data_q;
    rd_valid_d  = rd_en;
    irq_any_d   = |ch_irq;
    if (sync_reset) begin
      read_data_d = '0;
      rd_valid_d  = 1'b0;
      irq_any_d   = 1'b0;
    end
  end

  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      irq_any_q   <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      irq_any_q   <= irq_any_d;
    end
  end

  assign read_data = read_data_q;
  assign rd_valid  = rd_valid_q;
  assign irq_any_o = irq_any_q;
  assign pit_irq_o = ch_irq;

endmodule

// File: tb/tb_pit_mch_regs.sv
// Self-checking bench for pit_mch_regs: read results go through a scoreboard queue,
// direct output checks are done inline in each scenario task.
module tb_pit_mch_regs;

  localparam int NUM_CH = 4;
  localparam int CS     = 16;

  logic              bus_clk;
  logic              async_rst_b;
  logic              sync_reset;
  logic              wr_en;
  logic [1:0]        wr_be;
  logic [4:0]        addr;
  logic              rd_en;
  logic [15:0]       write_bus;
  logic [15:0]       read_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] cnt_flag_i;
  logic [NUM_CH*CS-1:0] mod_value;
  logic [NUM_CH*4-1:0]  pit_pre_scl;
  logic [NUM_CH-1:0] pit_slave;
  logic [NUM_CH-1:0] cnt_en_o;
  logic [NUM_CH-1:0] pit_irq_o;
  logic              irq_any_o;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb_q[$];

  pit_mch_regs #(
    .NUM_CH(NUM_CH), .COUNT_SIZE(CS), .DWIDTH(16), .NO_PRESCALE(1'b1), .ADDR_W(5)
  ) dut (
    .bus_clk(bus_clk), .async_rst_b(async_rst_b), .sync_reset(sync_reset),
    .wr_en(wr_en), .wr_be(wr_be), .addr(addr), .rd_en(rd_en),
    .write_bus(write_bus), .read_data(read_data), .rd_valid(rd_valid),
    .cnt_flag_i(cnt_flag_i), .mod_value(mod_value), .pit_pre_scl(pit_pre_scl),
    .pit_slave(pit_slave), .cnt_en_o(cnt_en_o), .pit_irq_o(pit_irq_o),
    .irq_any_o(irq_any_o)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  // Scoreboard: every rd_valid pulse must match the oldest queued expectation.
  always @(negedge bus_clk) begin
    if (rd_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL read_unexpected: rd_valid with data %h, none expected", read_data);
      end else begin
        logic [15:0] exp_v;
        exp_v = sb_q.pop_front();
        if (read_data !== exp_v) begin
          errors++;
          $display("[TB] FAIL read_data: got %h expected %h", read_data, exp_v);
        end
      end
    end
  end

  task automatic write_reg(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge bus_clk);
    addr = a; write_bus = d; wr_be = be; wr_en = 1'b1;
    @(negedge bus_clk);
    wr_en = 1'b0; wr_be = 2'b00;
  endtask

  task automatic read_reg(input logic [4:0] a, input logic [15:0] exp_v);
    @(negedge bus_clk);
    addr = a; rd_en = 1'b1;
    sb_q.push_back(exp_v);
    @(negedge bus_clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_flag(input logic [NUM_CH-1:0] m);
    @(negedge bus_clk);
    cnt_flag_i = m;
    @(negedge bus_clk);
    cnt_flag_i = '0;
  endtask

  task automatic test_reset();
    async_rst_b = 1'b0; sync_reset = 1'b0; wr_en = 1'b0; wr_be = 2'b00;
    addr = '0; rd_en = 1'b0; write_bus = '0; cnt_flag_i = '0;
    repeat (3) @(negedge bus_clk);
    async_rst_b = 1'b1;
    @(negedge bus_clk);
    checks++;
    if ({mod_value, pit_pre_scl, pit_slave, cnt_en_o, pit_irq_o, irq_any_o, read_data, rd_valid} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: mod=%h pre=%h slv=%b en=%b irq=%b any=%b rd=%h v=%b, all required 0",
               mod_value, pit_pre_scl, pit_slave, cnt_en_o, pit_irq_o, irq_any_o, read_data, rd_valid);
    end
    for (int a = 0; a <= 4 * NUM_CH; a++) read_reg(5'(a), 16'h0000);
    read_reg(5'd31, 16'h0000);
  endtask

  task automatic test_mod_byte_enables();
    write_reg(5'd9, 16'hA5C3, 2'b01);
    checks++;
    if (mod_value[2*CS +: CS] !== 16'h00C3) begin
      errors++;
      $display("[TB] FAIL mod_be_low: got %h expected %h", mod_value[2*CS +: CS], 16'h00C3);
    end
    read_reg(5'd9, 16'h00C3);
    write_reg(5'd9, 16'hA5C3, 2'b10);
    checks++;
    if (mod_value[2*CS +: CS] !== 16'hA5C3) begin
      errors++;
      $display("[TB] FAIL mod_be_high: got %h expected %h", mod_value[2*CS +: CS], 16'hA5C3);
    end
    write_reg(5'd9, 16'hFFFF, 2'b00);
    checks++;
    if (mod_value[2*CS +: CS] !== 16'hA5C3) begin
      errors++;
      $display("[TB] FAIL mod_be_none: got %h expected %h", mod_value[2*CS +: CS], 16'hA5C3);
    end
    read_reg(5'd9, 16'hA5C3);
  endtask

  task automatic test_prescale();
    write_reg(5'd0, 16'h8F00, 2'b11);
    checks++;
    if (pit_pre_scl !== 16'h0000 || pit_slave !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL prescale_forced: pre=%h slave=%b expected pre=0000 slave=0001", pit_pre_scl, pit_slave);
    end
    read_reg(5'd0, 16'h8000);
    write_reg(5'd3, 16'hFFFF, 2'b11);
    read_reg(5'd3, 16'h0000);
  endtask

  task automatic test_gctrl();
    write_reg(5'd16, 16'h0005, 2'b11);
    checks++;
    if (cnt_en_o !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL gctrl_start: got %b expected %b", cnt_en_o, 4'b0101);
    end
    write_reg(5'd16, 16'h0105, 2'b11);
    checks++;
    if (cnt_en_o !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL gctrl_stop_wins: got %b expected %b", cnt_en_o, 4'b0100);
    end
    write_reg(5'd16, 16'h0400, 2'b01);
    checks++;
    if (cnt_en_o !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL gctrl_stop_be: got %b expected %b", cnt_en_o, 4'b0100);
    end
    read_reg(5'd8, 16'h0001);
    read_reg(5'd0, 16'h8000);
  endtask

  task automatic test_irq();
    write_reg(5'd4, 16'h0002, 2'b11);
    pulse_flag(4'b0010);
    checks++;
    if (pit_irq_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL irq_early: got %b expected %b", pit_irq_o, 4'b0000);
    end
    @(negedge bus_clk);
    checks++;
    if (pit_irq_o !== 4'b0010 || irq_any_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_rise: irq=%b any=%b expected irq=0010 any=0", pit_irq_o, irq_any_o);
    end
    @(negedge bus_clk);
    checks++;
    if (irq_any_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_any_rise: got %b expected 1", irq_any_o);
    end
    read_reg(5'd6, 16'h0001);
    pulse_flag(4'b0010);
    read_reg(5'd6, 16'h0003);
    read_reg(5'd16, 16'h0202);
    write_reg(5'd6, 16'h0003, 2'b01);
    checks++;
    if (pit_irq_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL irq_hold_after_w1c: got %b expected %b", pit_irq_o, 4'b0010);
    end
    @(negedge bus_clk);
    checks++;
    if (pit_irq_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL irq_fall_after_w1c: got %b expected %b", pit_irq_o, 4'b0000);
    end
    read_reg(5'd6, 16'h0000);
    pulse_flag(4'b0010);
    @(negedge bus_clk);
    write_reg(5'd4, 16'h0000, 2'b11);
    checks++;
    if (pit_irq_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL irq_hold_after_ien: got %b expected %b", pit_irq_o, 4'b0010);
    end
    @(negedge bus_clk);
    checks++;
    if (pit_irq_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL irq_fall_after_ien: got %b expected %b", pit_irq_o, 4'b0000);
    end
    read_reg(5'd6, 16'h0001);
  endtask

  task automatic test_w1c_race();
    pulse_flag(4'b1000);
    @(negedge bus_clk);
    addr = 5'd14; write_bus = 16'h0001; wr_be = 2'b01; wr_en = 1'b1; cnt_flag_i = 4'b1000;
    @(negedge bus_clk);
    wr_en = 1'b0; wr_be = 2'b00; cnt_flag_i = '0;
    read_reg(5'd14, 16'h0001);
    write_reg(5'd14, 16'h0001, 2'b01);
    read_reg(5'd14, 16'h0000);
  endtask

  task automatic test_back_to_back();
    @(negedge bus_clk);
    addr = 5'd1; write_bus = 16'h1234; wr_be = 2'b11; wr_en = 1'b1; rd_en = 1'b1;
    sb_q.push_back(16'h0000);
    @(negedge bus_clk);
    wr_en = 1'b0; wr_be = 2'b00;
    addr = 5'd1; sb_q.push_back(16'h1234);
    @(negedge bus_clk);
    addr = 5'd9; sb_q.push_back(16'hA5C3);
    @(negedge bus_clk);
    addr = 5'd8; sb_q.push_back(16'h0001);
    @(negedge bus_clk);
    rd_en = 1'b0;
    @(negedge bus_clk);
    checks++;
    if (rd_valid !== 1'b0 || read_data !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL read_hold: valid=%b data=%h expected valid=0 data=0001", rd_valid, read_data);
    end
  endtask

  task automatic test_sync_reset();
    @(negedge bus_clk);
    sync_reset = 1'b1; addr = 5'd1; write_bus = 16'h5555; wr_be = 2'b11; wr_en = 1'b1;
    cnt_flag_i = 4'b0001;
    @(negedge bus_clk);
    sync_reset = 1'b0; wr_en = 1'b0; wr_be = 2'b00; cnt_flag_i = '0;
    checks++;
    if (mod_value !== '0 || cnt_en_o !== 4'b0000 || read_data !== 16'h0000 || pit_slave !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL sync_reset: mod=%h en=%b rd=%h slv=%b, all required 0",
               mod_value, cnt_en_o, read_data, pit_slave);
    end
    read_reg(5'd16, 16'h0000);
  endtask

  task automatic test_async_reset_mid_read();
    write_reg(5'd1, 16'h00FF, 2'b11);
    write_reg(5'd0, 16'h0003, 2'b11);
    pulse_flag(4'b0001);
    @(negedge bus_clk);
    @(negedge bus_clk);
    checks++;
    if (irq_any_o !== 1'b1 || pit_irq_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL pre_reset_irq: irq=%b any=%b expected irq=0001 any=1", pit_irq_o, irq_any_o);
    end
    read_reg(5'd2, 16'h0001);
    @(negedge bus_clk);
    addr = 5'd2; rd_en = 1'b1;
    #2 async_rst_b = 1'b0;
    #1;
    checks++;
    if ({mod_value, pit_pre_scl, pit_slave, cnt_en_o, pit_irq_o, irq_any_o, read_data, rd_valid} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset_outputs: mod=%h en=%b irq=%b any=%b rd=%h v=%b, all required 0",
               mod_value, cnt_en_o, pit_irq_o, irq_any_o, read_data, rd_valid);
    end
    @(negedge bus_clk);
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_rd_valid: got %b expected 0", rd_valid);
    end
    @(negedge bus_clk);
    async_rst_b = 1'b1;
    read_reg(5'd2, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_mod_byte_enables();
    test_prescale();
    test_gctrl();
    test_irq();
    test_w1c_race();
    test_back_to_back();
    test_sync_reset();
    test_async_reset_mid_read();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge bus_clk);
    repeat (2) @(negedge bus_clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL read_timeout: %0d reads outstanding, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pit_mch_regs.md
# pit_mch_regs

Multi-channel register file for the programmable interval timer. It holds the control, modulo and interrupt state for NUM_CH independent counters behind one address-decoded bus port. Compared with the single-channel register block, it adds per-channel sticky rollover and overflow status (write-1-to-clear), registered read-back, synchronized multi-channel start/stop, and a combined interrupt. It sits between the bus interface and NUM_CH counter cores.

## Interface
- NUM_CH, 4, number of timer channels (1..8)
- COUNT_SIZE, 16, modulo width per channel (8..16)
- DWIDTH, 16, bus data width (8 or 16; at 8, write_bus is replicated to both bytes)
- NO_PRESCALE, 1'b0, when 1 the prescaler field is forced to 0 on output and on read-back
- ADDR_W, 5, word-address width (must satisfy 2^ADDR_W > 4*NUM_CH)

Ports:
- bus_clk  in  1  register clock
- async_rst_b  in  1  reset, asynchronous, active-low
- sync_reset  in  1  synchronous reset, same effect as async reset
- wr_en  in  1  write strobe
- wr_be  in  2  byte enables [1]=bits 15:8, [0]=bits 7:0
- addr  in  ADDR_W  word address for read and write
- rd_en  in  1  read strobe
- write_bus  in  DWIDTH  write data
- read_data  out  16  registered read data
- rd_valid  out  1  read data valid pulse
- cnt_flag_i  in  NUM_CH  per-channel rollover pulse from the counters
- mod_value  out  NUM_CH*COUNT_SIZE  packed modulo values, channel 0 in the LSBs
- pit_pre_scl  out  NUM_CH*4  packed prescaler values
- pit_slave  out  NUM_CH  slave-mode bits
- cnt_en_o  out  NUM_CH  counter enables
- pit_irq_o  out  NUM_CH  per-channel interrupt
- irq_any_o  out  1  OR of pit_irq_o, registered

## Operation
- Per-channel word map, base ch*4:
  - +0 CTRL: slave[15], pre[11:8], ien[1], en[0]
  - +1 MOD: modulo value
  - +2 STATUS: ovf[1], flg[0], write-1-to-clear
  - +3 reserved: reads 0, writes ignored
- Global word at 4*NUM_CH:
  - Write GCTRL: data[NUM_CH-1:0] is the start mask and sets en; data[8+NUM_CH-1:8] is the stop mask and clears en. All selected channels change on the same edge. If start and stop are both set for a channel, stop wins.
  - Read: {pit_irq_o[NUM_CH-1:8]..., flg bits [7:0]}. In practice: flg summary in bits [NUM_CH-1:0], pit_irq_o in bits [8+NUM_CH-1:8].
- Unmapped addresses: reads return 0, writes are ignored.
- Byte enables apply per byte on every writable register; wr_be=0 means no write.
- MOD bits at COUNT_SIZE and above are ignored on write and read 0.
- flg is set on any cycle where cnt_flag_i[ch]=1.
  - If flg is already 1 (and not being cleared that cycle), ovf is also set.
  - A W1C write in the same cycle as a cnt_flag_i pulse leaves flg=1 (set wins). ovf is cleared only if ovf was written with 1.
- pit_irq_o[ch] is registered from flg & ien. Clearing ien drops the irq one cycle later, but flg is retained.
- Reset (async or sync) sets all outputs and registers to 0: mod_value, pit_pre_scl, pit_slave, cnt_en_o, pit_irq_o, irq_any_o, read_data, rd_valid, flg, ovf.

## Timing
- Writes take effect on the edge that samples wr_en, so outputs change one cycle after the strobe.
- Reads: rd_en at edge N gives read_data and rd_valid=1 after edge N. read_data holds until the next read; rd_valid is a single-cycle pulse.
- Read and write to the same address in the same cycle: the read returns the old value.
- cnt_flag_i at edge N:
  - flg=1 after N.
  - pit_irq_o=1 after N+1 (if ien).
  - irq_any_o=1 after N+2.
- sync_reset takes priority over wr_en and cnt_flag_i in the same cycle.
- Reset mid-read discards the pending rd_valid.

## Structure
- Shared package pit_pkg holds the register offsets (CTRL=0, MOD=1, STATUS=2), the GCTRL stop-mask bit offset (8) and the field bit positions. The single-channel block uses the same constants.
- One sub-module, pit_ch_regs: it holds one channel's CTRL, MOD, STATUS and irq state, and is instantiated NUM_CH times via generate. The top level holds the address decode, GCTRL fan-out, read mux and irq_any_o.

## Test plan
- Reset, then read every address 0..4*NUM_CH → all reads 0 and all outputs 0.
- Write MOD ch2 = 16'hA5C3 with wr_be=2'b01, then with 2'b10 → mod_value ch2 = 16'h00C3, then 16'hA5C3. With NO_PRESCALE=1, writing CTRL pre=4'hF → pit_pre_scl=0 and reads 0.
- Write GCTRL 16'h0005 → cnt_en_o=4'b0101 on the same edge. Then write 16'h0105 → ch0 disabled (stop wins), ch2 stays enabled.
- ien ch1=1, pulse cnt_flag_i[1] → flg=1, then pit_irq_o[1] one cycle later, then irq_any_o one cycle after that. A second pulse sets ovf. Writing STATUS=2'b11 clears both, and irq falls one cycle later.
- W1C of flg ch3 in the same cycle as cnt_flag_i[3] → flg stays 1.
- Assert async_rst_b low mid-sequence with flags set and a read pending → all outputs 0 immediately and no rd_valid pulse.
